seq_double_dabble: RTL and testbench
====================================

Name: seq_double_dabble

Overview:
- Multi-cycle, parametrised binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, processing one input bit per clock.
- Successor to the fixed 6-bit, two-digit combinational converter. Adds generic operand width and digit count, optional signed input, overflow detection and a start/busy/done handshake.
- Feeds the display/decoder path that consumes packed BCD digits.

Parameters:
- BIN_W, 6, operand width in bits (>=2).
- DIGITS, 2, number of BCD output digits (>=1).
- SIGNED, 0, 0 = i_Bin unsigned; 1 = i_Bin two's complement, magnitude converted, sign reported on o_Neg.

Ports:
- i_Clk  input  1  system clock, rising edge.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Start  input  1  request a conversion; sampled only in IDLE.
- i_Bin  input  BIN_W  operand; sampled on the accepted i_Start cycle only.
- o_Busy  output  1  high from the cycle after acceptance through the DONE cycle, inclusive.
- o_Done  output  1  single-cycle pulse when the result is valid.
- o_Bcd  output  4*DIGITS  packed BCD; digit k at bits [4k+3:4k], k=0 is ones. Holds its value until the next o_Done.
- o_Neg  output  1  input was negative (SIGNED=1 only; tied 0 when SIGNED=0). Updated with o_Bcd.
- o_Ovf  output  1  value did not fit in DIGITS digits. Updated with o_Bcd.

Behaviour:
- Reset, asynchronous, while i_Rst_n=0: state=IDLE; o_Busy=0, o_Done=0, o_Bcd=0, o_Neg=0, o_Ovf=0; scratch registers and bit counter cleared.
- State IDLE:
  - i_Start=1 latches the operand into a BIN_W shift register.
  - SIGNED=1 and i_Bin[BIN_W-1]=1: latch the magnitude (-i_Bin, taken as BIN_W-bit unsigned, so -2^(BIN_W-1) is handled correctly) and set the internal neg flag.
  - On acceptance: BCD scratch cleared, sticky ovf cleared, counter=BIN_W, next state CONV.
- State CONV, each cycle:
  - For every digit in scratch: if digit>=5, add 3 (all digits in parallel, combinationally).
  - Shift {scratch, operand} left by 1; operand MSB enters scratch bit 0.
  - If the adjusted scratch MSB (bit 4*DIGITS-1) is 1 before the shift, set sticky ovf.
  - Decrement counter. When the counter reaches 0 after this cycle's shift, next state DONE.
- State DONE, one cycle:
  - o_Done=1.
  - o_Bcd, o_Neg and o_Ovf registered from scratch and flags on the entry edge, so they are valid in the same cycle as o_Done.
  - Next state IDLE.
- Latency: i_Start accepted at edge N; o_Done high during cycle N+BIN_W+1; o_Busy high for BIN_W+1 cycles.
- i_Start while o_Busy=1 (including the DONE cycle): ignored, no queueing. i_Bin changes during CONV have no effect.
- i_Start in the first IDLE cycle after DONE is accepted, giving back-to-back throughput of one result per BIN_W+2 cycles.
- On overflow, o_Bcd holds the low DIGITS digits of the true result (truncated), and o_Ovf=1.
- Zero input: o_Bcd=0, o_Neg=0 (no negative zero), o_Ovf=0.
- Reset asserted mid-conversion aborts immediately, with all outputs at reset values. The first i_Start after release starts a fresh conversion.
- No combinational path from inputs to outputs.

Test Plan:
- Defaults (6,2,0): reset, then i_Start with i_Bin=63 -> o_Done in cycle 7 after acceptance; o_Bcd=8'h63, o_Ovf=0, o_Busy high for exactly 7 cycles.
- Defaults: sweep i_Bin 0..63 back-to-back, re-asserting i_Start the cycle after each o_Done -> every o_Bcd matches the decimal value. i_Bin=0 gives 8'h00.
- DIGITS=1, BIN_W=6: i_Bin=45 -> o_Bcd=4'h5, o_Ovf=1. Then i_Bin=9 -> o_Bcd=4'h9, o_Ovf=0 (sticky flag cleared per conversion).
- SIGNED=1, BIN_W=8, DIGITS=3:
  - i_Bin=8'h80 -> o_Bcd=12'h128, o_Neg=1.
  - i_Bin=8'h7F -> o_Bcd=12'h127, o_Neg=0.
  - i_Bin=8'hFF -> o_Bcd=12'h001, o_Neg=1.
- Defaults: i_Start with 37, then i_Start with 12 on cycle 3 of the conversion -> second request ignored; single o_Done with o_Bcd=8'h37.
- Defaults: i_Rst_n pulsed low mid-conversion of 50 -> outputs 0 immediately, no o_Done. After release, i_Start with 21 -> o_Bcd=8'h21.

Source files
------------

// File: rtl/seq_double_dabble.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Optional two's-complement input: the magnitude is converted and the sign is reported separately.
module seq_double_dabble #(
    parameter int unsigned BIN_W  = 6,
    parameter int unsigned DIGITS = 2,
    parameter int unsigned SIGNED = 0
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Start,
    input  logic [BIN_W-1:0]      i_Bin,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic [4*DIGITS-1:0]   o_Bcd,
    output logic                  o_Neg,
    output logic                  o_Ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic               neg_out_q, neg_out_d;
    logic               ovf_out_q, ovf_out_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic               ovf_next;

    // Add 3 to every scratch digit that is 5 or more, all digits in parallel.
    always_comb begin
        logic [3:0] digit;
        adj   = '0;
        digit = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            digit          = bcd_q[4*k +: 4];
            adj[4*k +: 4]  = (digit >= 4'd5) ? 4'(digit + 4'd3) : digit;
        end
    end

    // One conversion step: shift the adjusted scratch left, operand MSB enters bit 0.
    always_comb begin
        bcd_shift = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
        ovf_next  = ovf_q | adj[BCD_W-1];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_out_d = bcd_out_q;
        neg_out_d = neg_out_q;
        ovf_out_d = ovf_out_q;

        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    if ((SIGNED != 0) && i_Bin[BIN_W-1]) begin
                        bin_d = BIN_W'(~i_Bin + 1'b1);
                        neg_d = 1'b1;
                    end else begin
                        bin_d = i_Bin;
                        neg_d = 1'b0;
                    end
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(BIN_W);
                    busy_d  = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bcd_d = bcd_shift;
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                ovf_d = ovf_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    bcd_out_d = bcd_shift;
                    neg_out_d = neg_q;
                    ovf_out_d = ovf_next;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_out_q <= '0;
            neg_out_q <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_out_q <= bcd_out_d;
            neg_out_q <= neg_out_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign o_Busy = busy_q;
    assign o_Done = done_q;
    assign o_Bcd  = bcd_out_q;
    assign o_Neg  = neg_out_q;
    assign o_Ovf  = ovf_out_q;

endmodule

// File: tb/tb_seq_double_dabble.sv
// Bench for seq_double_dabble: three configurations checked against an arithmetic reference.
module tb_seq_double_dabble;

    logic        clk;
    logic        rst_n;
    logic        start0, start1, start2;
    logic [5:0]  bin0, bin1;
    logic [7:0]  bin2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [7:0]  bcd0;
    logic [3:0]  bcd1;
    logic [11:0] bcd2;
    logic        neg0, neg1, neg2;
    logic        ovf0, ovf1, ovf2;

    int errs   = 0;
    int checks = 0;

    seq_double_dabble #(.BIN_W(6), .DIGITS(2), .SIGNED(0)) u_dut0 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start0), .i_Bin(bin0),
        .o_Busy(busy0), .o_Done(done0), .o_Bcd(bcd0), .o_Neg(neg0), .o_Ovf(ovf0));

    seq_double_dabble #(.BIN_W(6), .DIGITS(1), .SIGNED(0)) u_dut1 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start1), .i_Bin(bin1),
        .o_Busy(busy1), .o_Done(done1), .o_Bcd(bcd1), .o_Neg(neg1), .o_Ovf(ovf1));

    seq_double_dabble #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_dut2 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start2), .i_Bin(bin2),
        .o_Busy(busy2), .o_Done(done2), .o_Bcd(bcd2), .o_Neg(neg2), .o_Ovf(ovf2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bw_of(input int idx);
        return (idx == 2) ? 8 : 6;
    endfunction

    function automatic int dg_of(input int idx);
        return (idx == 0) ? 2 : ((idx == 1) ? 1 : 3);
    endfunction

    function automatic logic busy_of(input int idx);
        return (idx == 0) ? busy0 : ((idx == 1) ? busy1 : busy2);
    endfunction

    function automatic logic done_of(input int idx);
        return (idx == 0) ? done0 : ((idx == 1) ? done1 : done2);
    endfunction

    function automatic logic neg_of(input int idx);
        return (idx == 0) ? neg0 : ((idx == 1) ? neg1 : neg2);
    endfunction

    function automatic logic ovf_of(input int idx);
        return (idx == 0) ? ovf0 : ((idx == 1) ? ovf1 : ovf2);
    endfunction

    function automatic logic [11:0] bcd_of(input int idx);
        return (idx == 0) ? {4'd0, bcd0} : ((idx == 1) ? {8'd0, bcd1} : bcd2);
    endfunction

    // Reference: decimal digits of the (magnitude of the) operand, truncated to the digit count.
    function automatic logic [11:0] ref_bcd(input int idx, input int val,
                                            output logic neg, output logic ovf);
        int w, v, m;
        logic [11:0] r;
        w   = bw_of(idx);
        v   = val & ((1 << w) - 1);
        neg = 1'b0;
        m   = v;
        if (idx == 2 && ((v >> (w - 1)) & 1) == 1) begin
            neg = 1'b1;
            m   = (1 << w) - v;
        end
        r = '0;
        for (int d = 0; d < dg_of(idx); d++) begin
            r = r | 12'((m % 10) << (4 * d));
            m = m / 10;
        end
        ovf = (m != 0);
        return r;
    endfunction

    task automatic drive(input int idx, input logic s, input int v);
        case (idx)
            0:       begin start0 = s; bin0 = 6'(v); end
            1:       begin start1 = s; bin1 = 6'(v); end
            default: begin start2 = s; bin2 = 8'(v); end
        endcase
    endtask

    // One conversion; optionally re-assert i_Start at conversion cycle intr (must be ignored).
    task automatic run(input int idx, input int val, input int intr);
        int lat, busy_n, extra, bw;
        logic [11:0] eb;
        logic en, eo;
        bw = bw_of(idx);
        eb = ref_bcd(idx, val, en, eo);
        @(negedge clk);
        check("done_pulse", 32'(done_of(idx)), 32'd0);
        drive(idx, 1'b1, val);
        @(posedge clk);
        #1;
        drive(idx, 1'b0, ~val);
        lat    = 0;
        busy_n = 0;
        for (int k = 1; k <= bw + 6 && lat == 0; k++) begin
            if (intr > 0 && k == intr)     drive(idx, 1'b1, 12);
            if (intr > 0 && k == intr + 1) drive(idx, 1'b0, 12);
            @(negedge clk);
            if (busy_of(idx)) busy_n++;
            if (done_of(idx)) lat = k;
        end
        check("latency", 32'(lat), 32'(bw + 1));
        check("busy_cycles", 32'(busy_n), 32'(bw + 1));
        check("bcd", 32'(bcd_of(idx)), 32'(eb));
        check("neg", 32'(neg_of(idx)), 32'(en));
        check("ovf", 32'(ovf_of(idx)), 32'(eo));
        if (intr > 0) begin
            extra = 0;
            repeat (bw + 3) begin
                @(negedge clk);
                if (done_of(idx)) extra++;
            end
            check("no_second_done", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        drive(2, 1'b0, 0);
        repeat (2) @(negedge clk);
        check("rst_busy", 32'({busy0, busy1, busy2}), 32'd0);
        check("rst_done", 32'({done0, done1, done2}), 32'd0);
        check("rst_bcd", 32'({bcd0, bcd1, bcd2}), 32'd0);
        check("rst_flags", 32'({neg0, ovf0, neg1, ovf1, neg2, ovf2}), 32'd0);
        rst_n = 1'b1;

        // Defaults: max value, full back-to-back sweep, ignored restart.
        run(0, 63, 0);
        for (int v = 0; v <= 63; v++) run(0, v, 0);
        run(0, 37, 3);

        // Reset mid-conversion aborts with outputs at reset values.
        @(negedge clk);
        drive(0, 1'b1, 50);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 50);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_bcd", 32'(bcd0), 32'd0);
        check("abort_done", 32'(done0), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done0) seen++;
        end
        rst_n = 1'b1;
        check("abort_no_done", 32'(seen), 32'd0);
        run(0, 21, 0);

        // Single digit: overflow then sticky flag cleared.
        run(1, 45, 0);
        run(1, 9, 0);
        for (int i = 0; i < 20; i++) run(1, int'($urandom_range(0, 63)), 0);

        // Signed 8-bit, three digits.
        run(2, 8'h80, 0);
        run(2, 8'h7F, 0);
        run(2, 8'hFF, 0);
        run(2, 0, 0);
        for (int i = 0; i < 30; i++) run(2, int'($urandom_range(0, 255)), 0);
        for (int i = 0; i < 20; i++) run(0, int'($urandom_range(0, 63)), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
